mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer_if.sv | 34 +++
 rtl/mdu_sequencer.sv | 77 +++++++
 tb/tb_mdu_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_sequencer_if.sv
// Handshake and datapath-control bundle between a requester/datapath (master)
// and the multiply/divide sequencer (slave).
interface mdu_sequencer_if #(
  parameter int PAR          = 32,
  parameter int OPCODE_WIDTH = 3
);
  localparam int CW = $clog2(PAR);

  logic                    start;
  logic [OPCODE_WIDTH-1:0] opCode;
  logic                    divisorZero;
  logic                    resultAck;
  logic                    ready;
  logic                    loadOperands;
  logic                    iterEn;
  logic                    lastIter;
  logic [CW-1:0]           iterCount;
  logic                    fixEn;
  logic [OPCODE_WIDTH-1:0] opCodeReg;
  logic                    divZeroSel;
  logic                    resultValid;

  modport master (
    output start, opCode, divisorZero, resultAck,
    input  ready, loadOperands, iterEn, lastIter, iterCount,
           fixEn, opCodeReg, divZeroSel, resultValid
  );

  modport slave (
    input  start, opCode, divisorZero, resultAck,
    output ready, loadOperands, iterEn, lastIter, iterCount,
           fixEn, opCodeReg, divZeroSel, resultValid
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Radix-2 multiply/divide control sequencer: IDLE -> LOAD -> CALC x PAR -> FIX -> DONE.
// Optional feature: define MDU_DIVZERO_BYPASS_EN to short-circuit division by zero.
module mdu_sequencer #(
  parameter int PAR          = 32,
  parameter int OPCODE_WIDTH = 3
) (
  input logic           clk,
  input logic           rst,
  mdu_sequencer_if.slave bus
);
  localparam int            CW   = $clog2(PAR);
  localparam logic [CW-1:0] LAST = CW'(PAR - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, FIX, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           iter_q;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic                    bypass_q;
  logic                    take_bypass;

`ifdef MDU_DIVZERO_BYPASS_EN
  assign take_bypass = (state == LOAD) && op_q[2] && bus.divisorZero;
`else
  logic unused_divisor_zero;
  assign unused_divisor_zero = bus.divisorZero;
  assign take_bypass         = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      iter_q   <= '0;
      op_q     <= '0;
      bypass_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start)
        op_q <= bus.opCode;
      if (state == LOAD)
        iter_q <= '0;
      else if (state == CALC)
        iter_q <= (iter_q == LAST) ? '0 : iter_q + 1'b1;
      if (state == LOAD)
        bypass_q <= take_bypass;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = take_bypass ? DONE : CALC;
      CALC:    if (iter_q == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (bus.resultAck) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs: decoded only from state, iteration index and latched flags.
  always_comb begin
    bus.ready        = (state == IDLE);
    bus.loadOperands = (state == LOAD);
    bus.iterEn       = (state == CALC);
    bus.lastIter     = (state == CALC) && (iter_q == LAST);
    bus.fixEn        = (state == FIX) && op_q[2] && !op_q[0];
    bus.resultValid  = (state == DONE);
    bus.divZeroSel   = (state == DONE) && bypass_q;
    bus.iterCount    = iter_q;
    bus.opCodeReg    = op_q;
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: timeline reference model, directed
// latency pins, then randomized traffic with resets.
module tb_mdu_sequencer;
  localparam int PAR = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_sequencer_if #(.PAR(PAR), .OPCODE_WIDTH(3)) bus ();
  mdu_sequencer #(.PAR(PAR), .OPCODE_WIDTH(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation is described by its age in cycles
  // since acceptance; every output follows from the age and the opcode.
  bit         m_active = 1'b0;
  int         m_age = 0;
  int         m_done_age = PAR + 3;
  bit         m_byp = 1'b0;
  logic [2:0] m_op = 3'b000;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_op     = 3'b000;
      m_byp    = 1'b0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active   = 1'b1;
        m_age      = 1;
        m_op       = bus.opCode;
        m_byp      = 1'b0;
        m_done_age = PAR + 3;
      end
    end else begin
`ifdef MDU_DIVZERO_BYPASS_EN
      if (m_age == 1 && m_op[2] && bus.divisorZero) begin
        m_byp      = 1'b1;
        m_done_age = 2;
      end
`endif
      if (m_age >= m_done_age && bus.resultAck) m_active = 1'b0;
      else m_age++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit in_calc;
      bit e_valid;
      in_calc = m_active && !m_byp && m_age >= 2 && m_age <= PAR + 1;
      e_valid = m_active && m_age >= m_done_age;
      check("ready",        32'(bus.ready),        32'(!m_active));
      check("loadOperands", 32'(bus.loadOperands), 32'(m_active && m_age == 1));
      check("iterEn",       32'(bus.iterEn),       32'(in_calc));
      check("lastIter",     32'(bus.lastIter),     32'(in_calc && m_age == PAR + 1));
      check("iterCount",    32'(bus.iterCount),    in_calc ? 32'(m_age - 2) : 32'd0);
      check("fixEn",        32'(bus.fixEn),
            32'(m_active && !m_byp && m_age == PAR + 2 && m_op[2] && !m_op[0]));
      check("resultValid",  32'(bus.resultValid),  32'(e_valid));
      check("divZeroSel",   32'(bus.divZeroSel),   32'(e_valid && m_byp));
      check("opCodeReg",    32'(bus.opCodeReg),    32'(m_op));
    end
  end

  // One operation from IDLE; event times are counted in cycles after acceptance.
  task automatic run_op(input logic [2:0] op, input bit dz, input int ack_wait, input bit poke,
                        output int t_load, output int t_last, output int t_fix,
                        output int t_valid, output int t_ready, output int n_valid,
                        output bit dzs);
    t_load = -1; t_last = -1; t_fix = -1; t_valid = -1; t_ready = -1;
    n_valid = 0; dzs = 1'b0;
    @(negedge clk);
    check("ready_before_start", 32'(bus.ready), 32'd1);
    bus.opCode      = op;
    bus.divisorZero = dz;
    bus.resultAck   = (ack_wait == 0);
    bus.start       = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
      if (poke && n == 10) begin bus.start = 1'b1; bus.opCode = 3'b111; end
      if (poke && n == 11) begin bus.start = 1'b0; bus.opCode = op; end
      if (bus.loadOperands && t_load < 0) t_load = n;
      if (bus.lastIter && t_last < 0) t_last = n;
      if (bus.fixEn && t_fix < 0) t_fix = n;
      if (bus.ready) begin t_ready = n; break; end
      if (bus.resultValid) begin
        if (t_valid < 0) begin t_valid = n; dzs = bus.divZeroSel; end
        n_valid++;
        if (ack_wait > 0) begin
          bus.start     = 1'b1;
          bus.opCode    = 3'b110;
          bus.resultAck = (n_valid > ack_wait);
        end
      end
    end
    bus.start = 1'b0; bus.resultAck = 1'b0; bus.divisorZero = 1'b0;
  endtask

  initial begin
    int tl, tt, tf, tv, tr, nv, nr;
    bit ds;
    bus.start = 1'b0; bus.opCode = 3'b000; bus.divisorZero = 1'b0; bus.resultAck = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",     32'(bus.ready),       32'd1);
    check("rst_iterCount", 32'(bus.iterCount),   32'd0);
    check("rst_opCodeReg", 32'(bus.opCodeReg),   32'd0);
    check("rst_valid",     32'(bus.resultValid), 32'd0);
    rst = 1'b0;

    run_op(3'b000, 1'b0, 0, 1'b0, tl, tt, tf, tv, tr, nv, ds);
    check("mul_t_load", 32'(tl), 32'd1);
    check("mul_t_last", 32'(tt), 32'd33);
    check("mul_no_fix", 32'(tf), 32'hFFFF_FFFF);
    check("mul_t_valid", 32'(tv), 32'd35);
    check("mul_t_ready", 32'(tr), 32'd36);

    run_op(3'b100, 1'b0, 0, 1'b0, tl, tt, tf, tv, tr, nv, ds);
    check("div_t_fix",   32'(tf), 32'd34);
    check("div_t_valid", 32'(tv), 32'd35);
    check("div_n_valid", 32'(nv), 32'd1);
    check("div_t_ready", 32'(tr), 32'd36);

    run_op(3'b001, 1'b0, 0, 1'b1, tl, tt, tf, tv, tr, nv, ds);
    check("poke_n_valid", 32'(nv), 32'd1);
    check("poke_t_valid", 32'(tv), 32'd35);
    check("poke_opreg",   32'(bus.opCodeReg), 32'd1);

    run_op(3'b010, 1'b0, 5, 1'b0, tl, tt, tf, tv, tr, nv, ds);
    check("hold_n_valid", 32'(nv), 32'd6);
    check("hold_t_ready", 32'(tr), 32'd41);
    check("hold_opreg",   32'(bus.opCodeReg), 32'd2);

    run_op(3'b101, 1'b1, 0, 1'b0, tl, tt, tf, tv, tr, nv, ds);
`ifdef MDU_DIVZERO_BYPASS_EN
    check("dz_t_valid", 32'(tv), 32'd2);
    check("dz_sel",     32'(ds), 32'd1);
    check("dz_no_last", 32'(tt), 32'hFFFF_FFFF);
    check("dz_t_ready", 32'(tr), 32'd3);
`else
    check("dz_t_valid", 32'(tv), 32'd35);
    check("dz_sel",     32'(ds), 32'd0);
    check("dz_t_last",  32'(tt), 32'd33);
    check("dz_t_ready", 32'(tr), 32'd36);
`endif

    // Abort mid-operation with reset.
    @(negedge clk);
    bus.opCode = 3'b011; bus.start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check("abort_ready",     32'(bus.ready),     32'd1);
    check("abort_iterCount", 32'(bus.iterCount), 32'd0);
    check("abort_opreg",     32'(bus.opCodeReg), 32'd0);
    nr = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.resultValid) nr++;
    end
    check("abort_no_valid", 32'(nr), 32'd0);

    // Randomized traffic: the per-cycle model compare does the checking.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.start       = ($urandom % 4) == 0;
      bus.opCode      = 3'($urandom);
      bus.divisorZero = ($urandom % 3) == 0;
      bus.resultAck   = ($urandom % 3) == 0;
      rst             = ($urandom % 400) == 0;
    end
    @(negedge clk);
    bus.start = 1'b0; bus.resultAck = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
